// File: rtl/cpu_mem_responder.sv
// Data-memory responder for the multicycle CPU memory port.
// One word read, word write or byte store at a time, completed after LATENCY cycles.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        SWB,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam bit         SINGLE   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [31:0]           wdata_q;
    logic                  swb_q;
    logic                  wr_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  req;
    logic                  req_err;
    logic                  enter_resp;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [1:0]            c_lane;
    logic [31:0]           c_wdata;
    logic                  c_swb;
    logic                  c_wr;
    logic                  c_err;

    assign req     = MemRead | MemWrite;
    assign req_err = (MemRead & MemWrite)
                   | ((addr >> (ADDR_WIDTH + 2)) != 32'd0)
                   | (!(MemWrite & SWB) & (addr[1:0] != 2'b00));

    // A single-cycle build commits on the sample edge, so use the live request.
    always_comb begin
        if (state_q == IDLE) begin
            c_idx   = addr[ADDR_WIDTH+1:2];
            c_lane  = addr[1:0];
            c_wdata = wdata;
            c_swb   = SWB;
            c_wr    = MemWrite;
            c_err   = req_err;
        end else begin
            c_idx   = idx_q;
            c_lane  = lane_q;
            c_wdata = wdata_q;
            c_swb   = swb_q;
            c_wr    = wr_q;
            c_err   = err_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (SINGLE) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit = enter_resp & reset & !c_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            wdata_q <= 32'd0;
            swb_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                idx_q   <= addr[ADDR_WIDTH+1:2];
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                swb_q   <= SWB;
                wr_q    <= MemWrite;
                err_q   <= req_err;
            end
            if (commit && !c_wr) begin
                rdata_q <= mem[c_idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && c_wr) begin
            if (c_swb) begin
                unique case (c_lane)
                    2'd0: mem[c_idx][7:0]   <= c_wdata[7:0];
                    2'd1: mem[c_idx][15:8]  <= c_wdata[7:0];
                    2'd2: mem[c_idx][23:16] <= c_wdata[7:0];
                    2'd3: mem[c_idx][31:24] <= c_wdata[7:0];
                    default: ;
                endcase
            end else begin
                mem[c_idx] <= c_wdata;
            end
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = (state_q == RESP);
    assign mem_busy  = (state_q != IDLE);
    assign addr_err  = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: a LATENCY=2 and a LATENCY=1 instance
// checked against a word-array reference model.
module tb_cpu_mem_responder;

    logic        clk;
    logic        reset;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic        swb_s  [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdata_o[2];
    logic        rdy_o  [2];
    logic        busy_o [2];
    logic        err_o  [2];

    int total = 0;
    int bad   = 0;
    int lat [2] = '{2, 1};

    logic [31:0] mdl  [2][256];
    logic [31:0] rd_m [2];

    cpu_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .MemRead(rd_s[0]), .MemWrite(wr_s[0]), .SWB(swb_s[0]),
        .addr(addr_s[0]), .wdata(wd_s[0]), .rdata(rdata_o[0]),
        .mem_ready(rdy_o[0]), .mem_busy(busy_o[0]), .addr_err(err_o[0])
    );

    cpu_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .MemRead(rd_s[1]), .MemWrite(wr_s[1]), .SWB(swb_s[1]),
        .addr(addr_s[1]), .wdata(wd_s[1]), .rdata(rdata_o[1]),
        .mem_ready(rdy_o[1]), .mem_busy(busy_o[1]), .addr_err(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drop(input int u);
        rd_s[u]   = 1'b0;
        wr_s[u]   = 1'b0;
        swb_s[u]  = 1'b0;
        addr_s[u] = 32'd0;
        wd_s[u]   = 32'd0;
    endtask

    function automatic bit is_err(input bit r, input bit w, input bit s,
                                  input logic [31:0] a);
        return (r && w) || (a >= 32'd1024) || (!(w && s) && (a % 4 != 0));
    endfunction

    // Applies one access to the model: word write, byte store or read.
    task automatic model(input int u, input bit w, input bit s,
                         input logic [31:0] a, input logic [31:0] d);
        int          wi;
        int          sh;
        logic [31:0] mask;
        wi = int'(a / 4);
        sh = 8 * int'(a % 4);
        if (w && s) begin
            mask = 32'hFF << sh;
            mdl[u][wi] = (mdl[u][wi] & ~mask) | ({24'd0, d[7:0]} << sh);
        end else if (w) begin
            mdl[u][wi] = d;
        end else begin
            rd_m[u] = mdl[u][wi];
        end
    endtask

    // Present a request for one cycle and check every cycle until idle.
    task automatic access(input int u, input bit r, input bit w,
                          input bit s, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int L;
        bit e;
        L = lat[u];
        e = is_err(r, w, s, a);
        @(negedge clk);
        rd_s[u]   = r;
        wr_s[u]   = w;
        swb_s[u]  = s;
        addr_s[u] = a;
        wd_s[u]   = d;
        @(posedge clk);
        for (int j = 0; j <= L; j++) begin
            @(negedge clk);
            if (j == 0) drop(u);
            if (j == L - 1 && !e) model(u, w, s, a, d);
            chk($sformatf("%s_rdy%0d", tag, j), 32'(rdy_o[u]),
                32'(j == L - 1));
            chk($sformatf("%s_busy%0d", tag, j), 32'(busy_o[u]),
                32'(j < L));
            chk($sformatf("%s_err%0d", tag, j), 32'(err_o[u]),
                32'(j == L - 1 && e));
            if (j >= L - 1) begin
                chk($sformatf("%s_rdata%0d", tag, j), rdata_o[u], rd_m[u]);
            end
        end
    endtask

    initial begin
        int p0;
        int p1;
        int kind;
        bit r;
        bit w;
        bit s;
        logic [31:0] a;
        logic [31:0] d;

        reset = 1'b0;
        drop(0);
        drop(1);
        rd_m[0] = 32'd0;
        rd_m[1] = 32'd0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_rdata", rdata_o[u], 32'd0);
            chk("rst_rdy", 32'(rdy_o[u]), 32'd0);
            chk("rst_busy", 32'(busy_o[u]), 32'd0);
            chk("rst_err", 32'(err_o[u]), 32'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            access(0, 1'b0, 1'b1, 1'b0, 32'(4 * i), $urandom, "init");
        end

        access(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "wr10");
        access(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, "rd10");
        chk("rd10_val", rdata_o[0], 32'hDEADBEEF);

        access(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h11223344, "wr10b");
        access(0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h000000AA, "sb11");
        access(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, "rd10b");
        chk("sb_val", rdata_o[0], 32'h1122AA44);

        access(0, 1'b1, 1'b0, 1'b0, 32'h12, 32'd0, "e_unal");
        access(0, 1'b1, 1'b0, 1'b0, 32'h400, 32'd0, "e_range");
        access(0, 1'b0, 1'b1, 1'b0, 32'h410, 32'hFFFFFFFF, "e_rngw");
        access(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55555555, "e_both");
        access(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, "rd_after_err");
        chk("err_nochg", rdata_o[0], 32'h1122AA44);

        // Request held through RESP is only re-sampled in the next IDLE.
        p0 = -1;
        p1 = -1;
        @(negedge clk);
        rd_s[0]   = 1'b1;
        addr_s[0] = 32'h10;
        for (int c = 0; c < 20 && p1 < 0; c++) begin
            @(negedge clk);
            if (rdy_o[0]) begin
                if (p0 < 0) p0 = c;
                else begin
                    p1 = c;
                    drop(0);
                end
            end
        end
        drop(0);
        rd_m[0] = mdl[0][4];
        chk("held_first", 32'(p0), 32'd1);
        chk("held_gap", 32'(p1 - p0), 32'd3);
        chk("held_rdata", rdata_o[0], rd_m[0]);
        @(negedge clk);
        chk("held_idle", 32'(busy_o[0]), 32'd0);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            r = 1'b0;
            w = 1'b0;
            s = 1'b0;
            if (kind <= 3) r = 1'b1;
            else if (kind <= 5) w = 1'b1;
            else if (kind <= 7) begin
                w = 1'b1;
                s = 1'b1;
            end else if (kind == 8) begin
                r = 1'b1;
                w = 1'b1;
                s = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
                a = $urandom | 32'h400;
            end
            if (kind <= 5 && i % 3 == 0) a = a & ~32'd3;
            access(0, r, w, s, a, d, $sformatf("rnd%0d", i));
        end

        // Reset during WAIT discards the pending write.
        access(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, "wr20");
        @(negedge clk);
        wr_s[0]   = 1'b1;
        addr_s[0] = 32'h20;
        wd_s[0]   = 32'h55;
        @(posedge clk);
        @(negedge clk);
        drop(0);
        chk("wait_busy", 32'(busy_o[0]), 32'd1);
        reset = 1'b0;
        #1;
        rd_m[0] = 32'd0;
        rd_m[1] = 32'd0;
        chk("mid_rst_rdata", rdata_o[0], 32'd0);
        chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
        chk("mid_rst_rdy", 32'(rdy_o[0]), 32'd0);
        chk("mid_rst_err", 32'(err_o[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_rdy", 32'(rdy_o[0]), 32'd0);
        end
        access(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, "rd20");
        chk("rd20_val", rdata_o[0], 32'h12345678);

        access(1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, "l1_wr");
        access(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, "l1_rd");
        chk("l1_val", rdata_o[1], 32'hCAFEF00D);
        access(1, 1'b0, 1'b1, 1'b1, 32'h43, 32'h77, "l1_sb");
        access(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'd0, "l1_rd2");
        chk("l1_sb_val", rdata_o[1], 32'h77FEF00D);
        access(1, 1'b1, 1'b0, 1'b0, 32'h41, 32'd0, "l1_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
